// File: rtl/pa_risc_pkg.sv
// Shared constants and forwarding-select encodings for the operand path.
// Used by operand_forward_stage and fwd_select.
package pa_risc_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

  localparam logic [AW-1:0] GR0 = '0;

endpackage

// File: rtl/operand_forward_stage_if.sv
// Decode/bypass/execute-facing bundle of operand_forward_stage.
// master drives decode and bypass inputs; slave is the stage itself.
interface operand_forward_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          ID_VALID;
  logic [AW-1:0] ID_RA;
  logic [AW-1:0] ID_RB;
  logic          ID_USE_A;
  logic          ID_USE_B;
  logic [DW-1:0] PA;
  logic [DW-1:0] PB;
  logic [AW-1:0] EX_RW;
  logic          EX_LE;
  logic          EX_LOAD;
  logic [DW-1:0] EX_RESULT;
  logic [AW-1:0] MEM_RW;
  logic          MEM_LE;
  logic [DW-1:0] MEM_RESULT;
  logic [AW-1:0] WB_RW;
  logic          WB_LE;
  logic [DW-1:0] WB_PW;
  logic          FLUSH;
  logic          STALL;
  logic          OUT_VALID;
  logic [DW-1:0] OPA;
  logic [DW-1:0] OPB;
  logic [1:0]    FWD_A;
  logic [1:0]    FWD_B;

  modport master (
    output ID_VALID, ID_RA, ID_RB, ID_USE_A, ID_USE_B,
    output PA, PB,
    output EX_RW, EX_LE, EX_LOAD, EX_RESULT,
    output MEM_RW, MEM_LE, MEM_RESULT,
    output WB_RW, WB_LE, WB_PW, FLUSH,
    input  STALL, OUT_VALID, OPA, OPB, FWD_A, FWD_B
  );

  modport slave (
    input  ID_VALID, ID_RA, ID_RB, ID_USE_A, ID_USE_B,
    input  PA, PB,
    input  EX_RW, EX_LE, EX_LOAD, EX_RESULT,
    input  MEM_RW, MEM_LE, MEM_RESULT,
    input  WB_RW, WB_LE, WB_PW, FLUSH,
    output STALL, OUT_VALID, OPA, OPB, FWD_A, FWD_B
  );

endinterface

// File: rtl/operand_forward_stage_fwd_select.sv
// Single-operand bypass priority mux: EX, then MEM, then WB, then regfile.
// GR0 always yields zero and is never bypassed.
module fwd_select
  import pa_risc_pkg::*;
#(
  parameter int DW = pa_risc_pkg::DW,
  parameter int AW = pa_risc_pkg::AW
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic [AW-1:0] ex_rw,
  input  logic          ex_le,
  input  logic          ex_load,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] mem_rw,
  input  logic          mem_le,
  input  logic [DW-1:0] mem_result,
  input  logic [AW-1:0] wb_rw,
  input  logic          wb_le,
  input  logic [DW-1:0] wb_pw,
  output logic [DW-1:0] val,
  output fwd_sel_e      sel,
  output logic          match
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Hits are made one-hot so the decoder below stays unique.
  assign is_zero = (src == AW'(GR0));
  assign ex_hit  = !is_zero && ex_le && !ex_load
                && (ex_rw == src);
  assign mem_hit = !is_zero && !ex_hit && mem_le
                && (mem_rw == src);
  assign wb_hit  = !is_zero && !ex_hit && !mem_hit
                && wb_le && (wb_rw == src);

  always_comb begin
    val = rf_data;
    sel = FWD_RF;
    unique case (1'b1)
      is_zero: begin
        val = '0;
        sel = FWD_RF;
      end
      ex_hit: begin
        val = ex_result;
        sel = FWD_EX;
      end
      mem_hit: begin
        val = mem_result;
        sel = FWD_MEM;
      end
      wb_hit: begin
        val = wb_pw;
        sel = FWD_WB;
      end
      default: begin
        val = rf_data;
        sel = FWD_RF;
      end
    endcase
  end

  assign match = (sel != FWD_RF);

endmodule

// File: rtl/operand_forward_stage.sv
// Operand fetch: bypass select, load-use stall, registered EX operands.
// Optional STALL_CNT/FWD_CNT counters when OPERAND_FWD_STATS_EN is defined.
module operand_forward_stage
  import pa_risc_pkg::*;
#(
  parameter int DW = pa_risc_pkg::DW,
  parameter int AW = pa_risc_pkg::AW
) (
  input  logic CLK,
  input  logic RST_N,
  operand_forward_stage_if.slave bus
`ifdef OPERAND_FWD_STATS_EN
  ,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FWD_CNT
`endif
);

  logic [DW-1:0] val_a;
  logic [DW-1:0] val_b;
  fwd_sel_e      sel_a;
  fwd_sel_e      sel_b;
  logic          match_a;
  logic          match_b;
  logic          hit_a;
  logic          hit_b;
  logic          hz;
  logic          stall;

  logic          out_valid;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  fwd_select #(.DW(DW), .AW(AW)) u_sel_a (
    .src        (bus.ID_RA),
    .rf_data    (bus.PA),
    .ex_rw      (bus.EX_RW),
    .ex_le      (bus.EX_LE),
    .ex_load    (bus.EX_LOAD),
    .ex_result  (bus.EX_RESULT),
    .mem_rw     (bus.MEM_RW),
    .mem_le     (bus.MEM_LE),
    .mem_result (bus.MEM_RESULT),
    .wb_rw      (bus.WB_RW),
    .wb_le      (bus.WB_LE),
    .wb_pw      (bus.WB_PW),
    .val        (val_a),
    .sel        (sel_a),
    .match      (match_a)
  );

  fwd_select #(.DW(DW), .AW(AW)) u_sel_b (
    .src        (bus.ID_RB),
    .rf_data    (bus.PB),
    .ex_rw      (bus.EX_RW),
    .ex_le      (bus.EX_LE),
    .ex_load    (bus.EX_LOAD),
    .ex_result  (bus.EX_RESULT),
    .mem_rw     (bus.MEM_RW),
    .mem_le     (bus.MEM_LE),
    .mem_result (bus.MEM_RESULT),
    .wb_rw      (bus.WB_RW),
    .wb_le      (bus.WB_LE),
    .wb_pw      (bus.WB_PW),
    .val        (val_b),
    .sel        (sel_b),
    .match      (match_b)
  );

  // Unused operands never stall, but are still selected above.
  assign hit_a = bus.ID_USE_A && (bus.ID_RA == bus.EX_RW);
  assign hit_b = bus.ID_USE_B && (bus.ID_RB == bus.EX_RW);
  assign hz    = bus.ID_VALID && bus.EX_LE && bus.EX_LOAD
              && (bus.EX_RW != AW'(GR0))
              && (hit_a || hit_b);
  assign stall = hz && !bus.FLUSH && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
    end else if (bus.FLUSH || hz) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= bus.ID_VALID;
      opa       <= val_a;
      opb       <= val_b;
      fwd_a     <= sel_a;
      fwd_b     <= sel_b;
    end
  end

  assign bus.STALL     = stall;
  assign bus.OUT_VALID = out_valid;
  assign bus.OPA       = opa;
  assign bus.OPB       = opb;
  assign bus.FWD_A     = fwd_a;
  assign bus.FWD_B     = fwd_b;

`ifdef OPERAND_FWD_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;
  logic        fwd_evt;

  assign fwd_evt = !bus.FLUSH && !hz && bus.ID_VALID
                && (match_a || match_b);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (fwd_evt && (fwd_cnt != 16'hFFFF))
        fwd_cnt <= fwd_cnt + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt;
  assign FWD_CNT   = fwd_cnt;
`else
  logic unused_match;
  assign unused_match = match_a ^ match_b;
`endif

endmodule

// File: tb/tb_operand_forward_stage.sv
// Bench for operand_forward_stage: vector table, corner sequences, random.
// Counter checks are included when OPERAND_FWD_STATS_EN is defined.
module tb_operand_forward_stage;

  localparam int W = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  operand_forward_stage_if #(.DW(W), .AW(A)) bus ();

`ifdef OPERAND_FWD_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;
`endif

  operand_forward_stage #(.DW(W), .AW(A)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
`ifdef OPERAND_FWD_STATS_EN
    ,
    .STALL_CNT (stall_cnt),
    .FWD_CNT   (fwd_cnt)
`endif
  );

  typedef struct {
    logic          id_valid;
    logic [A-1:0]  ra;
    logic [A-1:0]  rb;
    logic          use_a;
    logic          use_b;
    logic [W-1:0]  pa;
    logic [W-1:0]  pb;
    logic [A-1:0]  ex_rw;
    logic          ex_le;
    logic          ex_load;
    logic [W-1:0]  ex_result;
    logic [A-1:0]  mem_rw;
    logic          mem_le;
    logic [W-1:0]  mem_result;
    logic [A-1:0]  wb_rw;
    logic          wb_le;
    logic [W-1:0]  wb_pw;
    logic          flush;
  } stim_t;

  typedef struct {
    string        name;
    stim_t        s;
    logic         stall;
    logic         ovalid;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [1:0]   fa;
    logic [1:0]   fb;
  } vec_t;

  int total = 0;
  int passed = 0;

  logic         m_valid;
  logic [W-1:0] m_opa;
  logic [W-1:0] m_opb;
  logic [1:0]   m_fa;
  logic [1:0]   m_fb;
  int           m_scnt;
  int           m_fcnt;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(stim_t s);
    bus.ID_VALID   = s.id_valid;
    bus.ID_RA      = s.ra;
    bus.ID_RB      = s.rb;
    bus.ID_USE_A   = s.use_a;
    bus.ID_USE_B   = s.use_b;
    bus.PA         = s.pa;
    bus.PB         = s.pb;
    bus.EX_RW      = s.ex_rw;
    bus.EX_LE      = s.ex_le;
    bus.EX_LOAD    = s.ex_load;
    bus.EX_RESULT  = s.ex_result;
    bus.MEM_RW     = s.mem_rw;
    bus.MEM_LE     = s.mem_le;
    bus.MEM_RESULT = s.mem_result;
    bus.WB_RW      = s.wb_rw;
    bus.WB_LE      = s.wb_le;
    bus.WB_PW      = s.wb_pw;
    bus.FLUSH      = s.flush;
  endtask

  // Newest producer wins; a load in EX cannot supply its data yet.
  function automatic logic [W+1:0] pick(logic [A-1:0] src,
                                        logic [W-1:0] rf, stim_t s);
    logic [A-1:0] rw [3];
    logic         le [3];
    logic [W-1:0] d  [3];
    if (src == 0) return '0;
    rw = '{s.ex_rw, s.mem_rw, s.wb_rw};
    le = '{s.ex_le && !s.ex_load, s.mem_le, s.wb_le};
    d  = '{s.ex_result, s.mem_result, s.wb_pw};
    for (int k = 0; k < 3; k++)
      if (le[k] && rw[k] == src) return {2'(3 - k), d[k]};
    return {2'd0, rf};
  endfunction

  function automatic logic hazard(stim_t s);
    return s.id_valid && s.ex_le && s.ex_load && s.ex_rw != 0
        && ((s.use_a && s.ra == s.ex_rw)
         || (s.use_b && s.rb == s.ex_rw));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_opa = 0; m_opb = 0; m_fa = 0; m_fb = 0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_edge(stim_t s);
    logic [W+1:0] a;
    logic [W+1:0] b;
    logic hz;
    hz = hazard(s);
    if (hz && !s.flush && m_scnt < 65535) m_scnt++;
    if (s.flush || hz) begin
      m_valid = 0;
    end else begin
      a = pick(s.ra, s.pa, s);
      b = pick(s.rb, s.pb, s);
      m_valid = s.id_valid;
      m_opa = a[W-1:0]; m_fa = a[W+1:W];
      m_opb = b[W-1:0]; m_fb = b[W+1:W];
      if (s.id_valid && (m_fa != 0 || m_fb != 0) && m_fcnt < 65535)
        m_fcnt++;
    end
  endtask

  task automatic apply(stim_t s);
    @(negedge clk);
    drive(s);
    #1;
  endtask

  task automatic clock(stim_t s);
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic chk_regs(string nm, logic v, logic [W-1:0] a,
                          logic [W-1:0] b, logic [1:0] fa, logic [1:0] fb);
    chk({nm, " valid"}, bus.OUT_VALID, v);
    chk({nm, " opa"}, bus.OPA, a);
    chk({nm, " opb"}, bus.OPB, b);
    chk({nm, " fwd_a"}, bus.FWD_A, fa);
    chk({nm, " fwd_b"}, bus.FWD_B, fb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t base, s, hzs, mems, r;
    vec_t  v;
    vec_t  tbl[$];

    base = '{default: '0};
    base.id_valid = 1; base.use_a = 1; base.use_b = 1;

    v = '{name: "", s: base, stall: 0, ovalid: 1,
          opa: 0, opb: 0, fa: 0, fb: 0};
    v.name = "plain"; v.s.ra = 3; v.s.pa = 20;
    v.opa = 20; tbl.push_back(v);

    v.name = "prio_ex"; v.s = base; v.s.ra = 5; v.s.rb = 6; v.s.pb = 11;
    v.s.ex_rw = 5; v.s.mem_rw = 5; v.s.wb_rw = 5;
    v.s.ex_le = 1; v.s.mem_le = 1; v.s.wb_le = 1;
    v.s.ex_result = 7; v.s.mem_result = 8; v.s.wb_pw = 9;
    v.opa = 7; v.fa = 3; v.opb = 11; v.fb = 0; tbl.push_back(v);

    v.name = "prio_mem"; v.s.ex_le = 0; v.opa = 8; v.fa = 2;
    tbl.push_back(v);

    v.name = "prio_wb"; v.s.mem_le = 0; v.opa = 9; v.fa = 1;
    tbl.push_back(v);

    v.name = "gr0"; v.s = base; v.s.ra = 3; v.s.pa = 20;
    v.s.rb = 0; v.s.pb = 55; v.s.ex_le = 1; v.s.ex_rw = 0;
    v.s.ex_result = 99;
    v.opa = 20; v.fa = 0; v.opb = 0; v.fb = 0; tbl.push_back(v);

    v.name = "unused_b"; v.s = base; v.s.ra = 7; v.s.pa = 1;
    v.s.rb = 6; v.s.pb = 13; v.s.use_b = 0;
    v.s.ex_le = 1; v.s.ex_load = 1; v.s.ex_rw = 6; v.s.ex_result = 99;
    v.opa = 1; v.opb = 13; v.fa = 0; v.fb = 0; tbl.push_back(v);

    v.name = "invalid"; v.s = base; v.s.id_valid = 0;
    v.s.ra = 4; v.s.pa = 77; v.s.ex_le = 1; v.s.ex_load = 1;
    v.s.ex_rw = 4; v.ovalid = 0; v.opa = 77; v.opb = 0;
    tbl.push_back(v);

    v.name = "load_gr0"; v.s = base; v.s.ra = 0; v.s.pa = 3;
    v.s.ex_le = 1; v.s.ex_load = 1; v.s.ex_rw = 0;
    v.s.rb = 9; v.s.pb = 5; v.s.wb_le = 1; v.s.wb_rw = 9;
    v.s.wb_pw = 66; v.ovalid = 1;
    v.opa = 0; v.fa = 0; v.opb = 66; v.fb = 1; tbl.push_back(v);

    drive(base);
    model_reset();
    #1 rst_n = 0;
    #1;
    chk_regs("reset", 0, 0, 0, 0, 0);
    chk("reset stall", bus.STALL, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      apply(tbl[i].s);
      chk({tbl[i].name, " stall"}, bus.STALL, tbl[i].stall);
      clock(tbl[i].s);
      chk_regs(tbl[i].name, tbl[i].ovalid, tbl[i].opa,
               tbl[i].opb, tbl[i].fa, tbl[i].fb);
    end

    s = base; s.ra = 3; s.pa = 33;
    apply(s);
    clock(s);
    chk_regs("lu_pre", 1, 33, 0, 0, 0);

    hzs = base; hzs.ra = 4; hzs.pa = 1;
    hzs.ex_le = 1; hzs.ex_load = 1; hzs.ex_rw = 4; hzs.ex_result = 5;
    apply(hzs);
    chk("lu stall", bus.STALL, 1);
    clock(hzs);
    chk_regs("lu bubble", 0, 33, 0, 0, 0);

    mems = base; mems.ra = 4; mems.pa = 1;
    mems.mem_le = 1; mems.mem_rw = 4; mems.mem_result = 42;
    apply(mems);
    chk("lu_mem stall", bus.STALL, 0);
    clock(mems);
    chk_regs("lu_mem", 1, 42, 0, 2, 0);

    s = hzs; s.flush = 1;
    apply(s);
    chk("flush stall", bus.STALL, 0);
    clock(s);
    chk_regs("flush", 0, 42, 0, 2, 0);

    apply(mems);
    clock(mems);
    chk_regs("pre_rst", 1, 42, 0, 2, 0);

    @(negedge clk);
    drive(hzs);
    rst_n = 0;
    #1;
    chk_regs("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst stall", bus.STALL, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      r.id_valid   = ($urandom_range(0, 7) != 0);
      r.ra         = 5'($urandom_range(0, 3));
      r.rb         = 5'($urandom_range(0, 3));
      r.use_a      = 1'($urandom);
      r.use_b      = 1'($urandom);
      r.pa         = $urandom;
      r.pb         = $urandom;
      r.ex_rw      = 5'($urandom_range(0, 3));
      r.ex_le      = 1'($urandom);
      r.ex_load    = ($urandom_range(0, 2) == 0);
      r.ex_result  = $urandom;
      r.mem_rw     = 5'($urandom_range(0, 3));
      r.mem_le     = 1'($urandom);
      r.mem_result = $urandom;
      r.wb_rw      = 5'($urandom_range(0, 3));
      r.wb_le      = 1'($urandom);
      r.wb_pw      = $urandom;
      r.flush      = ($urandom_range(0, 7) == 0);
      apply(r);
      chk("rnd stall", bus.STALL, hazard(r) && !r.flush);
      clock(r);
      chk_regs("rnd", m_valid, m_opa, m_opb, m_fa, m_fb);
    end

`ifdef OPERAND_FWD_STATS_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("fwd_cnt", fwd_cnt, m_fcnt);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_forward_stage.md
Name: operand_forward_stage

Overview:
- Operand-fetch pipeline stage sitting directly downstream of register_file.
- Consumes raw register_file read data (PA/PB) for the instruction in decode.
- Selects the newest value for each operand from EX, MEM or WB, or from the register file.
- Detects load-use hazards and presents registered operands to the execute stage one clock later.

Parameters:
- DW, 32, data width of operands and results.
- AW, 5, register address width (32 general registers; GR0 reads as zero).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, asynchronous, active-low.
- ID_VALID  in  1  decode stage holds a valid instruction.
- ID_RA  in  AW  source register A address (also drives register_file RA).
- ID_RB  in  AW  source register B address (also drives register_file RB).
- ID_USE_A  in  1  instruction actually reads operand A.
- ID_USE_B  in  1  instruction actually reads operand B.
- PA  in  DW  register_file port A data.
- PB  in  DW  register_file port B data.
- EX_RW  in  AW  destination register of the instruction in EX.
- EX_LE  in  1  EX instruction writes a register.
- EX_LOAD  in  1  EX instruction is a load.
- EX_RESULT  in  DW  ALU result in EX.
- MEM_RW  in  AW  destination register in MEM.
- MEM_LE  in  1  MEM instruction writes a register.
- MEM_RESULT  in  DW  MEM-stage result.
- WB_RW  in  AW  writeback address (same net as register_file RW).
- WB_LE  in  1  writeback enable (same net as register_file EN).
- WB_PW  in  DW  writeback data (same net as register_file PW).
- FLUSH  in  1  kill the decode instruction (branch redirect).
- STALL  out  1  hold PC and decode stage this cycle.
- OUT_VALID  out  1  registered operands are valid for EX.
- OPA  out  DW  registered operand A.
- OPB  out  DW  registered operand B.
- FWD_A  out  2  registered source select for A: 0 regfile, 1 WB, 2 MEM, 3 EX.
- FWD_B  out  2  registered source select for B, same encoding as FWD_A.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - OUT_VALID=0, OPA=0, OPB=0, FWD_A=0, FWD_B=0.
  - STALL forced 0 while RST_N=0.
  - Release takes effect at the first rising edge after deassertion.
- Operand select (combinational, per operand X in {A,B}, source address S):
  - S==0: value 0, select 0. Never forwarded, even if a stage writes GR0.
  - Else, first match in priority order:
    - EX_LE & EX_RW==S & !EX_LOAD -> EX_RESULT, select 3.
    - MEM_LE & MEM_RW==S -> MEM_RESULT, select 2.
    - WB_LE & WB_RW==S -> WB_PW, select 1. Write-through: covers a same-cycle register_file write.
    - Otherwise PA/PB, select 0.
- Load-use hazard: hz = ID_VALID & EX_LE & EX_LOAD & EX_RW!=0 & ((ID_USE_A & ID_RA==EX_RW) | (ID_USE_B & ID_RB==EX_RW)).
- STALL = hz & !FLUSH (combinational, same cycle).
- Register update on each rising edge, evaluated in this order:
  - FLUSH=1: OUT_VALID<=0, OPA/OPB/FWD hold. FLUSH wins over a stall.
  - Else hz=1: bubble. OUT_VALID<=0, OPA/OPB/FWD hold. Decode holds. The next cycle re-evaluates with the load now in MEM, so operands are taken via select 2.
  - Else: OUT_VALID<=ID_VALID, OPA/OPB<=selected values, FWD_A/FWD_B<=selects. Values load even when ID_VALID=0 (don't-care data).
- Latency: 1 clock from decode-side inputs to OPA/OPB.
- An unused operand (ID_USE_x=0) never causes a stall but is still selected and registered.
- Reset asserted mid-stall clears OUT_VALID immediately. No pending state survives reset.

Optional Feature:
- Macro: OPERAND_FWD_STATS_EN.
- Defined:
  - Extra outputs STALL_CNT[15:0] and FWD_CNT[15:0], both reset to 0.
  - STALL_CNT increments on every edge where STALL=1.
  - FWD_CNT increments on every edge where a non-flushed, non-stalled valid instruction registers a nonzero select on A or B (+1 per instruction, not per operand).
  - Both counters saturate at 16'hFFFF.
- Undefined: no counters and no extra ports. Functional behaviour is identical.

Decomposition:
- Shared package pa_risc_pkg:
  - DW/AW constants.
  - FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EX=3 encodings.
  - GR0 address constant.
- Sub-module fwd_select: purely combinational single-operand priority mux plus match flag. Instantiated twice (A and B).
- Stall logic and the pipeline register stay in the top module.

Test Plan:
- Reset then no hazards:
  - Stimulus: RA=3, PA=20, all LE=0, ID_VALID=1.
  - Next edge: OPA=20, FWD_A=0, OUT_VALID=1.
- Priority:
  - Stimulus: RA=5; EX_RW=MEM_RW=WB_RW=5, all LE=1, EX_LOAD=0; EX_RESULT=7, MEM_RESULT=8, WB_PW=9.
  - Expect: OPA=7, FWD_A=3.
  - Then drop EX_LE: OPA=8.
  - Then drop MEM_LE: OPA=9.
- GR0:
  - Stimulus: RB=0, PB=55, EX_LE=1, EX_RW=0, EX_RESULT=99.
  - Expect: OPB=0, FWD_B=0.
- Load-use:
  - Stimulus: EX_LOAD=1, EX_RW=4, RA=4, USE_A=1.
  - Expect: STALL=1 that cycle, OUT_VALID=0 after the edge.
  - Next cycle: load moves to MEM (MEM_RW=4, MEM_RESULT=42). Expect STALL=0, OPA=42, FWD_A=2.
- Flush over stall:
  - Stimulus: hazard condition as in the load-use scenario, plus FLUSH=1.
  - Expect: STALL=0, OUT_VALID=0, OPA unchanged.
- Async reset mid-operation:
  - Stimulus: drop RST_N between edges while OUT_VALID=1, OPA=42.
  - Expect: OUT_VALID=0, OPA=0 immediately, before the next edge.
